// File: rtl/sd_spi_host.sv
// sd_spi_host
//
// Minimal SD-card SPI-mode host engine. It runs one single-block transfer of
// a 64-bit payload per request: CMD17 (read) or CMD24 (write). It builds the
// 48-bit command frame with its CRC7, waits for and checks the R1 response,
// then runs the read-token/data/CRC16 phase or the gap/token/data/CRC16/
// data-response/busy phase. Every card wait is bounded by TIMEOUT cycles.
// Chip select and SPI clock generation are outside this block: one bit moves
// per clk cycle.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   req_valid  request present (only looked at while idle)
//   req_ready  high only while idle
//   req_write  1 = CMD24 write, 0 = CMD17 read
//   req_addr   block address, zero-extended to the 32-bit command argument
//   req_wdata  write payload, captured at acceptance
//   rsp_valid  one-cycle completion pulse (first idle cycle)
//   rsp_rdata  read data, updated only when a read completes its data phase
//   rsp_err    0 ok, 1 timeout, 2 R1 nonzero, 3 data CRC / data response bad
//   MOSI       registered serial data to the card, idles high
//   MISO       serial data from the card, sampled on the rising edge

module sd_spi_host #(
    parameter int TIMEOUT      = 1023,
    parameter int WR_GAP_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        MOSI,
    input  logic        MISO
);

    // The cycle counter serves both as bit counter and as wait-timeout
    // counter; it must hold TIMEOUT and the longest write gap.
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (TW > 10) ? TW : 10;
    localparam int GAP_ONES = 8 * WR_GAP_BYTES + 7;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_ZERO = CNT_W'(GAP_ONES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_ONES);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_7      = CNT_W'(7);
    localparam logic [CNT_W-1:0] C_15     = CNT_W'(15);
    localparam logic [CNT_W-1:0] C_47     = CNT_W'(47);
    localparam logic [CNT_W-1:0] C_63     = CNT_W'(63);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT_R1,
        ST_R1,
        ST_RD_TOKEN,
        ST_RD_DATA,
        ST_RD_CRC,
        ST_WR_GAP,
        ST_WR_DATA,
        ST_WR_CRC,
        ST_WR_DRESP_WAIT,
        ST_WR_DRESP,
        ST_WR_BUSY
    } state_t;

    // One step of CRC7 (x^7 + x^3 + 1), MSB-first serial form.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_calc(input logic [39:0] m);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, m[i]);
        end
        return c;
    endfunction

    // One step of CRC16-CCITT (x^16 + x^12 + x^5 + 1), MSB-first serial form.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_wr;
    logic [63:0]      wdata_l;
    logic [46:0]      cmd_sr;     // frame bits still to send after bit 47
    logic [63:0]      shift_sr;   // read data in / write data out
    logic [6:0]       r8_sr;      // R1 / data-response bits collected so far
    logic [14:0]      rcrc_sr;    // received CRC16 bits collected so far
    logic [15:0]      crc16_r;
    logic             mosi_r;

    logic [5:0]  cmd_idx;
    logic [39:0] cmd_body;
    logic [47:0] cmd_frame;
    logic [15:0] wr_crc_next;
    logic [7:0]  r8_full;
    logic [15:0] rcrc_full;

    assign cmd_idx     = req_write ? 6'd24 : 6'd17;
    assign cmd_body    = {2'b01, cmd_idx, 16'h0000, req_addr};
    assign cmd_frame   = {cmd_body, crc7_calc(cmd_body), 1'b1};
    assign wr_crc_next = crc16_step(crc16_r, shift_sr[63]);
    assign r8_full     = {r8_sr, MISO};
    assign rcrc_full   = {rcrc_sr, MISO};

    assign req_ready = (state == ST_IDLE);
    assign MOSI      = mosi_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mosi_r    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 2'd0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            // MOSI idles high; only the transmit states override this.
            mosi_r    <= 1'b1;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        is_wr   <= req_write;
                        wdata_l <= req_wdata;
                        cmd_sr  <= cmd_frame[46:0];
                        mosi_r  <= cmd_frame[47];
                        state   <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (cnt == C_47) begin
                        cnt   <= '0;
                        state <= ST_WAIT_R1;
                    end else begin
                        mosi_r <= cmd_sr[46];
                        cmd_sr <= {cmd_sr[45:0], 1'b1};
                        cnt    <= cnt + C_ONE;
                    end
                end

                // The first low MISO sample is R1 bit 7 (always 0).
                ST_WAIT_R1: begin
                    if (!MISO) begin
                        r8_sr <= 7'h00;
                        cnt   <= C_ONE;
                        state <= ST_R1;
                    end else if (cnt == TMO_LAST) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 2'd1;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                ST_R1: begin
                    r8_sr <= r8_full[6:0];
                    if (cnt == C_7) begin
                        cnt <= '0;
                        if (r8_full != 8'h00) begin
                            state     <= ST_IDLE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 2'd2;
                        end else if (is_wr) begin
                            state <= ST_WR_GAP;
                        end else begin
                            state <= ST_RD_TOKEN;
                        end
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                // Only the final 0 of the 8'hFE token matters.
                ST_RD_TOKEN: begin
                    if (!MISO) begin
                        cnt     <= '0;
                        crc16_r <= 16'h0000;
                        state   <= ST_RD_DATA;
                    end else if (cnt == TMO_LAST) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 2'd1;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                ST_RD_DATA: begin
                    shift_sr <= {shift_sr[62:0], MISO};
                    crc16_r  <= crc16_step(crc16_r, MISO);
                    if (cnt == C_63) begin
                        cnt   <= '0;
                        state <= ST_RD_CRC;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                ST_RD_CRC: begin
                    rcrc_sr <= rcrc_full[14:0];
                    if (cnt == C_15) begin
                        cnt       <= '0;
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= shift_sr;
                        rsp_err   <= (rcrc_full == crc16_r) ? 2'd0 : 2'd3;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                // All-ones gap bytes plus the seven leading ones of 8'hFE,
                // then the token's trailing 0, all while in this state.
                ST_WR_GAP: begin
                    if (cnt == GAP_LAST) begin
                        shift_sr <= wdata_l;
                        mosi_r   <= wdata_l[63];
                        crc16_r  <= 16'h0000;
                        cnt      <= '0;
                        state    <= ST_WR_DATA;
                    end else begin
                        if (cnt == GAP_ZERO) begin
                            mosi_r <= 1'b0;
                        end
                        cnt <= cnt + C_ONE;
                    end
                end

                // CRC is folded over the bit currently on the line, so the
                // last data edge already launches the first CRC bit.
                ST_WR_DATA: begin
                    crc16_r <= wr_crc_next;
                    if (cnt == C_63) begin
                        mosi_r <= wr_crc_next[15];
                        cnt    <= '0;
                        state  <= ST_WR_CRC;
                    end else begin
                        mosi_r   <= shift_sr[62];
                        shift_sr <= {shift_sr[62:0], 1'b0};
                        cnt      <= cnt + C_ONE;
                    end
                end

                ST_WR_CRC: begin
                    if (cnt == C_15) begin
                        cnt   <= '0;
                        state <= ST_WR_DRESP_WAIT;
                    end else begin
                        mosi_r  <= crc16_r[14];
                        crc16_r <= {crc16_r[14:0], 1'b0};
                        cnt     <= cnt + C_ONE;
                    end
                end

                ST_WR_DRESP_WAIT: begin
                    if (!MISO) begin
                        r8_sr <= 7'h00;
                        cnt   <= C_ONE;
                        state <= ST_WR_DRESP;
                    end else if (cnt == TMO_LAST) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 2'd1;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                ST_WR_DRESP: begin
                    r8_sr <= r8_full[6:0];
                    if (cnt == C_7) begin
                        cnt <= '0;
                        if (r8_full != 8'h05) begin
                            state     <= ST_IDLE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 2'd3;
                        end else begin
                            state <= ST_WR_BUSY;
                        end
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                ST_WR_BUSY: begin
                    if (MISO) begin
                        cnt       <= '0;
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 2'd0;
                    end else if (cnt == TMO_LAST) begin
                        cnt       <= '0;
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 2'd1;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_host.sv
// Directed bench for sd_spi_host: the initial block plays host and card,
// one bit per clock, and checks outputs #1 after each rising edge.
module tb_sd_spi_host;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mosi;
    logic        miso;

    int total = 0;
    int bad   = 0;
    int vcount = 0;

    sd_spi_host #(.TIMEOUT(TMO), .WR_GAP_BYTES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .MOSI      (mosi),
        .MISO      (miso)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) vcount++;
    end

    // Reference CRCs as plain polynomial long division (init 0, MSB first).
    function automatic logic [6:0] ref_crc7(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        end
        return v[6:0];
    endfunction

    function automatic logic [15:0] ref_crc16(input logic [63:0] d);
        logic [79:0] v;
        v = {d, 16'b0};
        for (int i = 79; i >= 16; i--) begin
            if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h11021;
        end
        return v[15:0];
    endfunction

    function automatic logic [63:0] exp_frame(input logic [5:0] cmd, input logic [15:0] a);
        logic [39:0] body;
        body = {2'b01, cmd, 16'h0000, a};
        return {16'h0000, body, ref_crc7(body), 1'b1};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the inputs.
    task automatic send_req(input logic w, input logic [15:0] a, input logic [63:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        cyc();
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 16'hFFFF;
        req_wdata = '1;
    endtask

    task automatic get_bits(input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[62:0], mosi};
            cyc();
        end
    endtask

    task automatic put_bits(input int n, input logic [63:0] v);
        for (int i = n - 1; i >= 0; i--) begin
            miso = v[i];
            cyc();
        end
        miso = 1'b1;
    endtask

    initial begin
        logic [63:0] v;
        int v0;
        logic [63:0] d1, d2, d3, d4;
        d1 = 64'h0123_4567_89AB_CDEF;
        d2 = 64'hDEAD_BEEF_0BAD_F00D;
        d3 = 64'hFEDC_BA98_7654_3210;
        d4 = 64'h55AA_1234_0F0F_8001;

        rst = 1'b1; miso = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) cyc();
        chk("rst_ready", {63'b0, req_ready}, 64'd1);
        chk("rst_mosi",  {63'b0, mosi}, 64'd1);
        chk("rst_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_err",   {62'b0, rsp_err}, 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        rst = 1'b0;
        cyc();

        // Read, addr 3, good CRC
        send_req(1'b0, 16'h0003, 64'h0);
        chk("rd_busy_ready", {63'b0, req_ready}, 64'd0);
        get_bits(48, v);
        chk("rd_frame", v, exp_frame(6'd17, 16'h0003));
        chk("rd_frame_b2_7", {58'b0, v[45:40]}, 64'b010001);
        v0 = vcount;
        put_bits(8, 64'h00);
        req_valid = 1'b1; req_addr = 16'h1234;
        repeat (3) cyc();
        req_valid = 1'b0;
        put_bits(8, 64'hFE);
        put_bits(64, d1);
        put_bits(16, {48'b0, ref_crc16(d1)});
        chk("rd_valid", {63'b0, rsp_valid}, 64'd1);
        chk("rd_rdata", rsp_rdata, d1);
        chk("rd_err", {62'b0, rsp_err}, 64'd0);
        chk("rd_done_ready", {63'b0, req_ready}, 64'd1);
        cyc();
        chk("rd_valid_drop", {63'b0, rsp_valid}, 64'd0);
        chk("rd_pulse_count", 64'(vcount - v0), 64'd1);

        // Write, addr 5, all-zero payload, good response and busy
        send_req(1'b1, 16'h0005, 64'h0);
        get_bits(48, v);
        chk("wr0_frame", v, exp_frame(6'd24, 16'h0005));
        chk("wr0_frame_b2_7", {58'b0, v[45:40]}, 64'b011000);
        put_bits(8, 64'h00);
        get_bits(16, v);
        chk("wr0_gap_token", v, 64'hFFFE);
        get_bits(64, v);
        chk("wr0_data", v, 64'h0);
        get_bits(16, v);
        chk("wr0_crc", v, 64'h0);
        chk("wr0_dresp_mosi", {63'b0, mosi}, 64'd1);
        put_bits(8, 64'h05);
        put_bits(8, 64'h00);
        chk("wr0_busy_hold", {63'b0, rsp_valid}, 64'd0);
        cyc();
        chk("wr0_valid", {63'b0, rsp_valid}, 64'd1);
        chk("wr0_err", {62'b0, rsp_err}, 64'd0);
        cyc();

        // Write, nonzero payload, card rejects data (8'h0B)
        send_req(1'b1, 16'hA5C3, d2);
        get_bits(48, v);
        chk("wr1_frame", v, exp_frame(6'd24, 16'hA5C3));
        put_bits(8, 64'h00);
        get_bits(16, v);
        get_bits(64, v);
        chk("wr1_data", v, d2);
        get_bits(16, v);
        chk("wr1_crc", v, {48'b0, ref_crc16(d2)});
        put_bits(8, 64'h0B);
        chk("wr1_valid", {63'b0, rsp_valid}, 64'd1);
        chk("wr1_err", {62'b0, rsp_err}, 64'd3);
        chk("wr1_rdata_kept", rsp_rdata, d1);
        cyc();

        // R1 timeout: card never answers
        send_req(1'b0, 16'h0007, 64'h0);
        get_bits(48, v);
        repeat (TMO - 1) cyc();
        chk("tmo_early", {63'b0, rsp_valid}, 64'd0);
        cyc();
        chk("tmo_valid", {63'b0, rsp_valid}, 64'd1);
        chk("tmo_err", {62'b0, rsp_err}, 64'd1);
        chk("tmo_rdata_kept", rsp_rdata, d1);
        cyc();

        // R1 = 8'h04 on read
        send_req(1'b0, 16'h0009, 64'h0);
        get_bits(48, v);
        put_bits(8, 64'h04);
        chk("r1_valid", {63'b0, rsp_valid}, 64'd1);
        chk("r1_err", {62'b0, rsp_err}, 64'd2);
        chk("r1_mosi", {63'b0, mosi}, 64'd1);
        cyc();

        // Read with one flipped CRC bit
        send_req(1'b0, 16'h0011, 64'h0);
        get_bits(48, v);
        put_bits(8, 64'h00);
        put_bits(8, 64'hFE);
        put_bits(64, d3);
        put_bits(16, {48'b0, ref_crc16(d3) ^ 16'h0100});
        chk("crc_valid", {63'b0, rsp_valid}, 64'd1);
        chk("crc_err", {62'b0, rsp_err}, 64'd3);
        chk("crc_rdata", rsp_rdata, d3);
        cyc();

        // Reset in the middle of WR_DATA
        send_req(1'b1, 16'h0002, 64'h0);
        get_bits(48, v);
        put_bits(8, 64'h00);
        get_bits(16, v);
        get_bits(10, v);
        chk("mid_data", v, 64'h0);
        chk("pre_rst_mosi", {63'b0, mosi}, 64'd0);
        v0 = vcount;
        rst = 1'b1;
        cyc();
        chk("mid_rst_mosi", {63'b0, mosi}, 64'd1);
        chk("mid_rst_ready", {63'b0, req_ready}, 64'd1);
        chk("mid_rst_valid", {63'b0, rsp_valid}, 64'd0);
        chk("mid_rst_rdata", rsp_rdata, 64'd0);
        req_valid = 1'b1; req_write = 1'b0;
        cyc();
        req_valid = 1'b0; rst = 1'b0;
        chk("rst_over_req_ready", {63'b0, req_ready}, 64'd1);
        repeat (3) cyc();
        chk("rst_over_req_mosi", {63'b0, mosi}, 64'd1);
        chk("mid_rst_no_pulse", 64'(vcount - v0), 64'd0);

        // New read after reset
        send_req(1'b0, 16'h0003, 64'h0);
        get_bits(48, v);
        chk("post_frame", v, exp_frame(6'd17, 16'h0003));
        put_bits(8, 64'h00);
        put_bits(8, 64'hFE);
        put_bits(64, d4);
        put_bits(16, {48'b0, ref_crc16(d4)});
        chk("post_valid", {63'b0, rsp_valid}, 64'd1);
        chk("post_rdata", rsp_rdata, d4);
        chk("post_err", {62'b0, rsp_err}, 64'd0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_spi_host.md
SD_SPI_HOST -- requirements
Module: sd_spi_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: max cycles waited for any card event (R1 start, read token, data response start, busy release).
REQ-002 SHALL have parameter WR_GAP_BYTES, default 1, legal range 1..32: all-ones bytes sent between R1 end and write token.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  host request present.
REQ-006 SHALL have port req_ready  output  1  high only in IDLE.
REQ-007 SHALL have port req_write  input  1  1 = CMD24 write, 0 = CMD17 read.
REQ-008 SHALL have port req_addr  input  16  block address, zero-extended to the 32-bit argument.
REQ-009 SHALL have port req_wdata  input  64  write payload.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  64  read data, valid with rsp_valid.
REQ-012 SHALL have port rsp_err  output  2  0 ok, 1 timeout, 2 R1 nonzero, 3 read CRC16 mismatch or data response not 8'h05.
REQ-013 SHALL have port MOSI  output  1  serial data to card, registered, idle 1.
REQ-014 SHALL have port MISO  input  1  serial data from card, sampled on posedge clk.

Function
REQ-015 SHALL accept a request on the posedge where req_valid && req_ready, latching write flag, address and wdata.
REQ-016 SHALL implement states IDLE, CMD, WAIT_R1, R1, RD_TOKEN, RD_DATA, RD_CRC, WR_GAP, WR_DATA, WR_CRC, WR_DRESP_WAIT, WR_DRESP, WR_BUSY.
REQ-017 SHALL in CMD shift 48 bits MSB first, one per cycle, starting the cycle after acceptance: 0, 1, cmd[5:0] (17 or 24), arg[31:0], CRC7[6:0], 1.
REQ-018 SHALL compute CRC7 with polynomial 0x09, init 0, over {2'b01, cmd, arg} (40 bits) MSB first.
REQ-019 SHALL in WAIT_R1 hold MOSI=1 until the first MISO==0 sample, which is R1 bit 7; R1 then collects the remaining 7 bits.
REQ-020 SHALL finish with rsp_err=2 if R1 != 8'h00, with no data phase.
REQ-021 SHALL for reads, in RD_TOKEN wait for MISO==0 (token end bit), then sample 64 data bits (RD_DATA) and 16 CRC bits (RD_CRC), MSB first.
REQ-022 SHALL compute CRC16 with polynomial 0x1021, init 0, over 64 data bits MSB first; mismatch sets rsp_err=3 while rsp_rdata still carries received data.
REQ-023 SHALL for writes, in WR_GAP drive MOSI=1 for 8*WR_GAP_BYTES+7 cycles then 0 (token 8'hFE tail), then 64 data bits and 16 CRC16 bits MSB first.
REQ-024 SHALL after write CRC hold MOSI=1, wait for MISO==0 (WR_DRESP_WAIT), collect 8 bits including that one; value != 8'h05 sets rsp_err=3 and skips WR_BUSY.
REQ-025 SHALL in WR_BUSY wait until MISO==1 sampled, then complete.
REQ-026 SHALL count cycles in every wait state with a counter cleared on entry; reaching TIMEOUT completes with rsp_err=1.
REQ-027 SHALL on completion return to IDLE and assert rsp_valid for exactly the first IDLE cycle; req_ready is high in that cycle, so a back-to-back request is accepted.
REQ-028 SHALL hold MOSI=1 in every state except CMD, WR_GAP token bit, WR_DATA and WR_CRC.
REQ-029 SHALL ignore req_valid outside IDLE; request inputs need not be held after acceptance.
REQ-030 SHALL keep rsp_rdata at its last value until the next read completes.

Reset
REQ-031 SHALL on rst=1 at a posedge: state IDLE, MOSI=1, req_ready=1 the cycle after, rsp_valid=0, rsp_err=0, rsp_rdata=0, counters 0.
REQ-032 SHALL abort any transfer in progress on reset with no rsp_valid for it; rst overrides a simultaneous request.

Verification
REQ-033 Read addr 16'h0003, card returns R1 00, token, data 64'h0123_4567_89AB_CDEF with correct CRC16 -> rsp_valid once, rsp_rdata=64'h0123456789ABCDEF, rsp_err=0; MOSI frame bits 2..7 = 010001.
REQ-034 Write addr 16'h0005 data 64'h0 -> 15 ones then 0 after R1, 64 zeros, CRC16 16'h0000; card 8'h05 and 8 busy cycles -> rsp_err=0 after MISO returns 1.
REQ-035 Card holds MISO=1 after command -> rsp_valid with rsp_err=1 exactly TIMEOUT cycles after WAIT_R1 entry.
REQ-036 Card returns R1 8'h04 on read -> rsp_err=2, no token wait, MOSI stays 1.
REQ-037 Read data with one flipped CRC bit -> rsp_err=3, rsp_rdata = received data.
REQ-038 rst asserted mid-WR_DATA -> MOSI=1 next cycle, req_ready=1, no rsp_valid; new read then completes normally.
